axis_video_fifo: RTL and testbench

Parametrised AXI4-Stream video FIFO with an optional input-side framing checker. Sits between a video source (camera/DMA) and a sink (processing or VDMA), absorbing back-pressure and carrying TDATA/TKEEP/TLAST/TUSER unchanged. Generalises the plain stream interface in data width, TUSER width and buffering depth, and adds frame-structure checking: SOF = TUSER[0], EOL = TLAST.

---
 rtl/axis_video_fifo.sv | 184 ++++++++++++++++++
 tb/tb_axis_video_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_fifo.sv
// AXI4-Stream video FIFO (first-word fall-through) with an optional input-side framing checker.
// Define AXIS_VIDEO_FIFO_FRAME_CHECK_EN to compile in the checker; otherwise err_* and frame_done are tied low.
module axis_video_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned UW    = 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [DW-1:0]            s_tdata,
    input  logic [DW/8-1:0]          s_tkeep,
    input  logic                     s_tlast,
    input  logic [UW-1:0]            s_tuser,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DW-1:0]            m_tdata,
    output logic [DW/8-1:0]          m_tkeep,
    output logic                     m_tlast,
    output logic [UW-1:0]            m_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    input  logic [15:0]              cfg_width,
    input  logic [15:0]              cfg_height,
    input  logic                     err_clr,
    output logic                     err_sof,
    output logic                     err_nosof,
    output logic                     err_eol_early,
    output logic                     err_eol_late,
    output logic                     frame_done
);
    localparam int unsigned KW = DW / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = UW + 1 + KW + DW;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          s_tready_q, m_tvalid_q;
    logic          push, pop;

    assign push = s_tvalid & s_tready_q;
    assign pop  = m_tvalid_q & m_tready;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage is reset so the output bus reads zero while empty after reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {s_tuser, s_tlast, s_tkeep, s_tdata};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            s_tready_q <= (level_d < LW'(DEPTH));
            m_tvalid_q <= (level_d != '0);
        end
    end

    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign level    = level_q;
    assign {m_tuser, m_tlast, m_tkeep, m_tdata} = mem_q[rd_ptr_q];

`ifdef AXIS_VIDEO_FIFO_FRAME_CHECK_EN
    logic [15:0] px_q, px_d, ln_q, ln_d, w_q, w_d, h_q, h_d;
    logic [15:0] p, l;
    logic        in_frame_q, in_frame_d;
    logic        sof;
    logic        set_sof, set_nosof, set_early, set_late, done_d;
    logic        err_sof_q, err_nosof_q, err_early_q, err_late_q, done_q;

    // Frame tracking on accepted input beats; a zero latched geometry leaves the checker idle.
    always_comb begin
        px_d       = px_q;
        ln_d       = ln_q;
        w_d        = w_q;
        h_d        = h_q;
        in_frame_d = in_frame_q;
        set_sof    = 1'b0;
        set_nosof  = 1'b0;
        set_early  = 1'b0;
        set_late   = 1'b0;
        done_d     = 1'b0;
        sof        = s_tuser[0];
        p          = px_q;
        l          = ln_q;
        if (push) begin
            if (sof) begin
                w_d = cfg_width;
                h_d = cfg_height;
            end
            if (w_d != 16'd0 && h_d != 16'd0) begin
                if (sof) begin
                    set_sof    = in_frame_q && (px_q != 16'd0 || ln_q != 16'd0);
                    p          = 16'd0;
                    l          = 16'd0;
                    in_frame_d = 1'b1;
                end
                if (!sof && !in_frame_q) begin
                    set_nosof = 1'b1;
                end else begin
                    set_early = s_tlast && (p < w_d - 16'd1);
                    set_late  = !s_tlast && (p == w_d - 16'd1);
                    if (s_tlast || p == w_d - 16'd1) begin
                        px_d = 16'd0;
                        if (l == h_d - 16'd1) begin
                            done_d     = 1'b1;
                            ln_d       = 16'd0;
                            in_frame_d = 1'b0;
                        end else begin
                            ln_d = l + 16'd1;
                        end
                    end else begin
                        px_d = p + 16'd1;
                    end
                end
            end
        end
    end

    // Sticky flags: a new error on the clearing cycle keeps the flag set.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            px_q        <= '0;
            ln_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            in_frame_q  <= 1'b0;
            err_sof_q   <= 1'b0;
            err_nosof_q <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            px_q        <= px_d;
            ln_q        <= ln_d;
            w_q         <= w_d;
            h_q         <= h_d;
            in_frame_q  <= in_frame_d;
            err_sof_q   <= (err_sof_q & ~err_clr) | set_sof;
            err_nosof_q <= (err_nosof_q & ~err_clr) | set_nosof;
            err_early_q <= (err_early_q & ~err_clr) | set_early;
            err_late_q  <= (err_late_q & ~err_clr) | set_late;
            done_q      <= done_d;
        end
    end

    assign err_sof       = err_sof_q;
    assign err_nosof     = err_nosof_q;
    assign err_eol_early = err_early_q;
    assign err_eol_late  = err_late_q;
    assign frame_done    = done_q;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{cfg_width, cfg_height, err_clr};
    assign err_sof       = 1'b0;
    assign err_nosof     = 1'b0;
    assign err_eol_early = 1'b0;
    assign err_eol_late  = 1'b0;
    assign frame_done    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_video_fifo.sv
// Scoreboard bench for axis_video_fifo (DW=32, UW=1, DEPTH=4): FIFO ordering, back-pressure, framing flags, async reset.
module tb_axis_video_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned UW    = 1;
    localparam int unsigned DEPTH = 4;
`ifdef AXIS_VIDEO_FIFO_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   s_tdata;
    logic [3:0]    s_tkeep;
    logic          s_tlast;
    logic [0:0]    s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic          m_tlast;
    logic [0:0]    m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic [2:0]    level;
    logic [15:0]   cfg_width, cfg_height;
    logic          err_clr;
    logic          err_sof, err_nosof, err_eol_early, err_eol_late, frame_done;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            pop_cnt = 0;
    int            done_cnt = 0;
    logic [37:0]   sb [$];

    always #5 clk = ~clk;

    axis_video_fifo #(.DW(DW), .UW(UW), .DEPTH(DEPTH)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .level(level), .cfg_width(cfg_width), .cfg_height(cfg_height), .err_clr(err_clr),
        .err_sof(err_sof), .err_nosof(err_nosof), .err_eol_early(err_eol_early),
        .err_eol_late(err_eol_late), .frame_done(frame_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare the presented beat with the oldest expected beat; pop on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_done === 1'b1) done_cnt++;
            if (m_tvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("m_unexpected_beat", 64'(m_tdata), 64'hDEAD_BEEF_0BAD_0BAD);
                end else begin
                    chk("m_beat", 64'({m_tuser, m_tlast, m_tkeep, m_tdata}), 64'(sb[0]));
                    if (m_tready === 1'b1) begin
                        void'(sb.pop_front());
                        pop_cnt++;
                    end
                end
            end
        end
    end

    // Drive one beat until accepted; optionally check flags/frame_done after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u,
                        input logic cf, input logic [3:0] ef, input logic ed);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_tready;
            if (acc) sb.push_back({u, l, k, d});
            @(posedge clk);
            #2;
            n++;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            chk("send_timeout", 64'(0), 64'(1));
        end else if (cf) begin
            chk("flags", 64'({err_sof, err_nosof, err_eol_early, err_eol_late}), 64'(CHK ? ef : 4'b0000));
            chk("frame_done", 64'(frame_done), 64'(CHK ? ed : 1'b0));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (level != 3'd0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_level", 64'(level), 64'(0));
        chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(posedge clk);
        #2;
        err_clr = 1'b0;
    endtask

    task automatic clean_frame(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            send(base + 32'(i), 4'hF, (i == 3 || i == 7), (i == 0), 1'b1, 4'b0000, (i == 7));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0; s_tvalid = 1'b0;
        m_tready = 1'b0; cfg_width = '0; cfg_height = '0; err_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_m_bus", 64'({m_tuser, m_tlast, m_tkeep, m_tdata}), 64'(0));
        chk("rst_flags", 64'({err_sof, err_nosof, err_eol_early, err_eol_late, frame_done}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("s_tready_after_rst", 64'(s_tready), 64'(1));

        // Fill to full with the sink stalled, then release
        for (int i = 0; i < 4; i++) send(32'hA500_0000 + 32'(i), 4'(i + 1), i[0], 1'b0, 1'b0, 4'b0, 1'b0);
        chk("full_level", 64'(level), 64'(4));
        chk("full_s_tready", 64'(s_tready), 64'(0));
        fork
            begin
                send(32'hA500_0004, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
                send(32'hA500_0005, 4'h3, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #3;
                chk("stall_level", 64'(level), 64'(4));
                chk("stall_s_tready", 64'(s_tready), 64'(0));
                m_tready = 1'b1;
            end
        join
        drain();
        chk("fill_pop_cnt", 64'(pop_cnt), 64'(6));

        // Continuous streaming: level pinned at 1, one beat out per cycle
        pop_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            send(32'h1234_5678 ^ (32'(i) * 32'h0101_0101), 4'(i), i[1], 1'b0, 1'b0, 4'b0, 1'b0);
            chk("stream_level", 64'(level), 64'(1));
        end
        chk("stream_pop_cnt", 64'(pop_cnt), 64'(99));
        drain();

        // Clean frame W=4 H=2
        cfg_width = 16'd4;
        cfg_height = 16'd2;
        done_cnt = 0;
        clean_frame(32'hF000_0000);
        drain();
        chk("frame_done_count", 64'(done_cnt), 64'(CHK ? 1 : 0));

        // Early EOL, then a line with no TLAST
        cfg_height = 16'd4;
        send(32'hE000_0000, 4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        send(32'hE000_0001, 4'hF, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        send(32'hE000_0002, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(32'hE100_0000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1, (i >= 3) ? 4'b0011 : 4'b0010, 1'b0);
        end
        clr_pulse();
        chk("flags_after_clr", 64'({err_sof, err_nosof, err_eol_early, err_eol_late}), 64'(0));

        // SOF mid-line restarts counters; a non-SOF beat after frame_done flags nosof
        send(32'hD000_0000, 4'hF, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        cfg_height = 16'd1;
        send(32'hD000_0001, 4'hF, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0);
        send(32'hD000_0002, 4'hF, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0);
        send(32'hD000_0003, 4'hF, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0);
        send(32'hD000_0004, 4'hF, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1);
        send(32'hD000_0005, 4'hF, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        drain();

        // Asynchronous reset mid-frame with three beats buffered
        m_tready = 1'b0;
        cfg_height = 16'd2;
        send(32'hC000_0000, 4'hF, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0);
        send(32'hC000_0001, 4'hF, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        send(32'hC000_0002, 4'hF, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        chk("pre_rst_level", 64'(level), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("arst_level", 64'(level), 64'(0));
        chk("arst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("arst_s_tready", 64'(s_tready), 64'(0));
        chk("arst_flags", 64'({err_sof, err_nosof, err_eol_early, err_eol_late, frame_done}), 64'(0));
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_tready = 1'b1;
        done_cnt = 0;
        clean_frame(32'hB000_0000);
        drain();
        chk("post_rst_done_count", 64'(done_cnt), 64'(CHK ? 1 : 0));
        chk("post_rst_flags", 64'({err_sof, err_nosof, err_eol_early, err_eol_late}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
